dtcm_arbiter: RTL and testbench

Two-port arbiter for the single-port data TCM: shares one DTCM access slot per cycle between the core load/store unit (port C) and the debug/loader DMA (port D). Sits between both requesters and the DTCM wrapper, issues the winning request on the memory port and routes the one-cycle-late read data back with a per-port valid. Port C has fixed priority. A compile-time anti-starvation counter guarantees port D forward progress.

---
 rtl/dtcm_arbiter_if.sv | 42 ++++
 rtl/dtcm_arbiter.sv | 98 +++++++++
 tb/tb_dtcm_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dtcm_arbiter_if.sv
// Request/response bundle between the two DTCM requesters, the arbiter and the DTCM wrapper.
// slave: arbiter view; master: requester + memory side.
interface dtcm_arbiter_if;
    logic        c_req;
    logic [31:0] c_addr;
    logic [3:0]  c_wen;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_wen;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] m_addr;
    logic [3:0]  m_wen;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  c_req, c_addr, c_wen, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_addr, d_wen, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_addr, m_wen, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_addr, c_wen, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_addr, d_wen, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_addr, m_wen, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dtcm_arbiter.sv
// Two-port DTCM arbiter: fixed C priority, one access per cycle, one-cycle read return.
// Define DTCM_ARB_FAIR_EN to add the port D anti-starvation counter.
module dtcm_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic           clk,
    input  logic           reset,
    dtcm_arbiter_if.slave  bus
);

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    if (CNT_W < 1 || STARVE_LIMIT < 1 || (STARVE_LIMIT >> CNT_W) != 0) begin : g_bad_cfg
        $error("CNT_W must hold STARVE_LIMIT and STARVE_LIMIT must be at least 1");
    end

    logic  force_d;
    logic  c_win;
    logic  d_win;
    logic  rsp_valid_d, rsp_valid_q;
    port_e rsp_port_d,  rsp_port_q;

`ifdef DTCM_ARB_FAIR_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_d, wait_cnt_q;

    assign force_d = bus.d_req && (wait_cnt_q == LIMIT);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.d_req || d_win) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_d = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the DTCM while reset is held.
    assign c_win = !reset && bus.c_req && !force_d;
    assign d_win = !reset && bus.d_req && (!bus.c_req || force_d);

    assign bus.c_gnt = c_win;
    assign bus.d_gnt = d_win;

    always_comb begin
        bus.m_addr  = '0;
        bus.m_wen   = '0;
        bus.m_wdata = '0;
        if (c_win) begin
            bus.m_addr  = bus.c_addr;
            bus.m_wen   = bus.c_wen;
            bus.m_wdata = bus.c_wdata;
        end else if (d_win) begin
            bus.m_addr  = bus.d_addr;
            bus.m_wen   = bus.d_wen;
            bus.m_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        rsp_valid_d = (c_win && bus.c_wen == '0) || (d_win && bus.d_wen == '0);
        rsp_port_d  = d_win ? PORT_D : PORT_C;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= PORT_C;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
        end
    end

    // A read granted just before reset rises must not produce a response.
    assign bus.c_rvalid = rsp_valid_q && !reset && (rsp_port_q == PORT_C);
    assign bus.d_rvalid = rsp_valid_q && !reset && (rsp_port_q == PORT_D);

    assign bus.c_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed bench for dtcm_arbiter with a DTCM memory, a per-cycle reference model and
// hand-computed expectations for the key scenarios (works with or without DTCM_ARB_FAIR_EN).
module tb_dtcm_arbiter;

    localparam int unsigned LIMIT = 8;
`ifdef DTCM_ARB_FAIR_EN
    localparam bit          FAIR        = 1'b1;
    localparam logic [19:0] EXP_D_MASK20 = 20'h20100;
    localparam logic [11:0] EXP_D_MASK12 = 12'h100;
`else
    localparam bit          FAIR        = 1'b0;
    localparam logic [19:0] EXP_D_MASK20 = 20'h00000;
    localparam logic [11:0] EXP_D_MASK12 = 12'h000;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dtcm_arbiter_if bus ();

    dtcm_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // DTCM: byte-enabled write at the edge, registered read data one cycle later.
    logic [31:0] dmem [1024];
    logic [31:0] mem_q;
    assign bus.m_rdata = mem_q;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.m_wen[b]) dmem[bus.m_addr[11:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
        end
        mem_q <= dmem[bus.m_addr[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who should win this cycle, what reaches memory, what comes back.
    logic [31:0] shadow [1024];
    int          starve;
    bit          pend_v, pend_d;
    logic [31:0] pend_data;

    initial begin
        bit          w_c, w_d, ev_c, ev_d;
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        starve = 0;
        pend_v = 1'b0;
        pend_d = 1'b0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            w_c = 1'b0;
            w_d = 1'b0;
            if (!reset) begin
                if (FAIR && bus.d_req && starve >= LIMIT) w_d = 1'b1;
                else if (bus.c_req)                       w_c = 1'b1;
                else if (bus.d_req)                       w_d = 1'b1;
            end
            ea = w_c ? bus.c_addr  : w_d ? bus.d_addr  : 32'h0;
            ew = w_c ? bus.c_wen   : w_d ? bus.d_wen   : 4'h0;
            ed = w_c ? bus.c_wdata : w_d ? bus.d_wdata : 32'h0;
            ev_c = pend_v && !pend_d && !reset;
            ev_d = pend_v &&  pend_d && !reset;

            chk("c_gnt",    bus.c_gnt,    w_c);
            chk("d_gnt",    bus.d_gnt,    w_d);
            chk("m_addr",   bus.m_addr,   ea);
            chk("m_wen",    bus.m_wen,    ew);
            chk("m_wdata",  bus.m_wdata,  ed);
            chk("c_rvalid", bus.c_rvalid, ev_c);
            chk("d_rvalid", bus.d_rvalid, ev_d);
            if (ev_c) chk("c_rdata", bus.c_rdata, pend_data);
            if (ev_d) chk("d_rdata", bus.d_rdata, pend_data);

            if (reset) begin
                starve = 0;
                pend_v = 1'b0;
            end else begin
                pend_v    = (w_c || w_d) && ew == 4'h0;
                pend_d    = w_d;
                pend_data = shadow[ea[11:2]];
                for (int b = 0; b < 4; b++) begin
                    if (ew[b]) shadow[ea[11:2]][8*b +: 8] = ed[8*b +: 8];
                end
                if (!bus.d_req || w_d)  starve = 0;
                else if (starve < LIMIT) starve++;
            end
        end
    end

    task automatic drive_c(input logic req, input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata);
        bus.c_req = req; bus.c_addr = addr; bus.c_wen = wen; bus.c_wdata = wdata;
    endtask

    task automatic drive_d(input logic req, input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata);
        bus.d_req = req; bus.d_addr = addr; bus.d_wen = wen; bus.d_wdata = wdata;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] mask_c20, mask_d20;
        logic [11:0] mask_d12;

        // Reset with both ports requesting a write.
        reset = 1'b1;
        drive_c(1'b1, 32'h100, 4'hF, 32'h1234_5678);
        drive_d(1'b1, 32'h104, 4'hF, 32'h8765_4321);
        @(negedge clk);
        chk("rst_c_gnt",    bus.c_gnt,    1'b0);
        chk("rst_d_gnt",    bus.d_gnt,    1'b0);
        chk("rst_m_wen",    bus.m_wen,    4'h0);
        chk("rst_c_rvalid", bus.c_rvalid, 1'b0);
        chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
        adv();
        adv();
        reset = 1'b0;
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        drive_d(1'b0, 32'h0, 4'h0, 32'h0);
        adv();

        // Port C write then read.
        drive_c(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk); chk("t1_wr_c_gnt", bus.c_gnt, 1'b1); adv();
        drive_c(1'b1, 32'h100, 4'h0, 32'h0);
        @(negedge clk); chk("t1_rd_c_gnt", bus.c_gnt, 1'b1); adv();
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1_c_rvalid", bus.c_rvalid, 1'b1);
        chk("t1_c_rdata",  bus.c_rdata,  32'hDEAD_BEEF);
        chk("t1_d_rvalid", bus.d_rvalid, 1'b0);
        adv();

        // Byte-lane write over an existing word.
        drive_c(1'b1, 32'h104, 4'hF, 32'h1122_3344); adv();
        drive_c(1'b1, 32'h104, 4'h1, 32'h0000_00AA); adv();
        drive_c(1'b1, 32'h104, 4'h0, 32'h0);         adv();
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2_c_rvalid", bus.c_rvalid, 1'b1);
        chk("t2_c_rdata",  bus.c_rdata,  32'h1122_33AA);
        adv();

        // 20 cycles of contention.
        drive_c(1'b1, 32'h300, 4'hF, 32'hC0C0_0001);
        drive_d(1'b1, 32'h304, 4'hF, 32'hD0D0_0001);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mask_c20[i] = bus.c_gnt;
            mask_d20[i] = bus.d_gnt;
            adv();
        end
        chk("t3_d_gnt_pattern", {12'h0, mask_d20}, {12'h0, EXP_D_MASK20});
        chk("t3_c_gnt_pattern", {12'h0, mask_c20}, {12'h0, ~EXP_D_MASK20});
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        drive_d(1'b0, 32'h0, 4'h0, 32'h0);
        adv();

        // Interleaved pipelined reads from both ports.
        drive_c(1'b1, 32'h200, 4'hF, 32'hA5A5_0001); adv();
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        drive_d(1'b1, 32'h204, 4'hF, 32'h5A5A_0002); adv();
        drive_d(1'b0, 32'h0, 4'h0, 32'h0);
        drive_c(1'b1, 32'h200, 4'h0, 32'h0);
        @(negedge clk); chk("t4_c_gnt", bus.c_gnt, 1'b1); adv();
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        drive_d(1'b1, 32'h204, 4'h0, 32'h0);
        @(negedge clk);
        chk("t4_n1_c_rvalid", bus.c_rvalid, 1'b1);
        chk("t4_n1_c_rdata",  bus.c_rdata,  32'hA5A5_0001);
        chk("t4_n1_d_rvalid", bus.d_rvalid, 1'b0);
        adv();
        drive_d(1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t4_n2_d_rvalid", bus.d_rvalid, 1'b1);
        chk("t4_n2_d_rdata",  bus.d_rdata,  32'h5A5A_0002);
        chk("t4_n2_c_rvalid", bus.c_rvalid, 1'b0);
        adv();

        // Build up some D wait, then reset right after a C read grant.
        drive_c(1'b1, 32'h300, 4'hF, 32'hC0C0_0002);
        drive_d(1'b1, 32'h304, 4'hF, 32'hD0D0_0002);
        for (int i = 0; i < 5; i++) adv();
        drive_c(1'b1, 32'h100, 4'h0, 32'h0);
        @(negedge clk); chk("t5_read_c_gnt", bus.c_gnt, 1'b1); adv();
        reset = 1'b1;
        drive_c(1'b1, 32'h300, 4'hF, 32'hC0C0_0003);
        @(negedge clk);
        chk("t5_rst_c_rvalid", bus.c_rvalid, 1'b0);
        chk("t5_rst_c_gnt",    bus.c_gnt,    1'b0);
        chk("t5_rst_d_gnt",    bus.d_gnt,    1'b0);
        adv();
        @(negedge clk); chk("t5_rst2_c_rvalid", bus.c_rvalid, 1'b0); adv();
        reset = 1'b0;
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        drive_d(1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); chk("t5_post_c_rvalid", bus.c_rvalid, 1'b0); adv();

        // Post-reset contention: the D wait count must start again from zero.
        drive_c(1'b1, 32'h300, 4'hF, 32'hC0C0_0004);
        drive_d(1'b1, 32'h304, 4'hF, 32'hD0D0_0004);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mask_d12[i] = bus.d_gnt;
            adv();
        end
        chk("t5_post_d_gnt_pattern", {20'h0, mask_d12}, {20'h0, EXP_D_MASK12});
        drive_c(1'b0, 32'h0, 4'h0, 32'h0);
        drive_d(1'b0, 32'h0, 4'h0, 32'h0);
        adv();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
